// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants, the per-axis total helper and the counter type
// shared by the VGA timing generator and its bench.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam bit DEF_SYNC_POL = 1'b0;
  localparam int DEF_WIN_W    = 200;
  localparam int DEF_WIN_H    = 200;
  localparam int DEF_CW       = 10;

  typedef logic [DEF_CW-1:0] count_t;

  function automatic int axis_total(input int active, input int fp, input int sync,
                                    input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: position register plus decodes of its next value (wrap, sync, active),
// so the parent can register every output in step with the counter.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE   = DEF_H_ACTIVE,
  parameter int FP       = DEF_H_FP,
  parameter int SYNC     = DEF_H_SYNC,
  parameter int BP       = DEF_H_BP,
  parameter bit SYNC_POL = DEF_SYNC_POL,
  parameter int CW       = DEF_CW
) (
  input  logic          clk_25M,
  input  logic          reset,
  input  logic          ce,
  input  logic          step,
  input  logic          restart,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_nxt,
  output logic          wrap,
  output logic          sync_nxt,
  output logic          active_nxt
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_FIRST = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_LAST  = CW'(ACTIVE + FP + SYNC - 1);

  always_comb begin
    wrap      = step && (count == LAST);
    count_nxt = count;
    if (restart || wrap) begin
      count_nxt = '0;
    end else if (step) begin
      count_nxt = count + 1'b1;
    end
    sync_nxt   = ((count_nxt >= SYNC_FIRST) && (count_nxt <= SYNC_LAST)) ? SYNC_POL : ~SYNC_POL;
    active_nxt = (count_nxt < ACT_END);
  end

  always_ff @(posedge clk_25M) begin
    if (reset) begin
      count <= '0;
    end else if (ce) begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with zero-skew registered decodes.
// Define VGA_TIMING_WINDOW_EN to build the per-frame picture window logic.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = DEF_SYNC_POL,
  parameter int WIN_W    = DEF_WIN_W,
  parameter int WIN_H    = DEF_WIN_H,
  parameter int CW       = DEF_CW
) (
  input  logic          clk_25M,
  input  logic          reset,
  input  logic          ce,
  input  logic [CW-1:0] win_x0,
  input  logic [CW-1:0] win_y0,
  output logic [CW-1:0] h_count,
  output logic [CW-1:0] v_count,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic          line_start,
  output logic          frame_start,
  output logic          win_en,
  output logic [CW-1:0] win_x,
  output logic [CW-1:0] win_y
);

  logic          started, restart;
  logic [CW-1:0] h_nxt, v_nxt;
  logic          h_wrap, v_wrap;
  logic          h_sync_nxt, v_sync_nxt;
  logic          h_act_nxt, v_act_nxt, act_nxt;

  // The first ce after reset presents 0,0 as a fresh frame instead of advancing.
  assign restart = ~started;
  assign act_nxt = h_act_nxt & v_act_nxt;

  always_ff @(posedge clk_25M) begin
    if (reset) begin
      started <= 1'b0;
    end else if (ce) begin
      started <= 1'b1;
    end
  end

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .SYNC_POL(SYNC_POL), .CW(CW)
  ) u_h_axis (
    .clk_25M(clk_25M), .reset(reset), .ce(ce), .step(1'b1), .restart(restart),
    .count(h_count), .count_nxt(h_nxt), .wrap(h_wrap),
    .sync_nxt(h_sync_nxt), .active_nxt(h_act_nxt)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .SYNC_POL(SYNC_POL), .CW(CW)
  ) u_v_axis (
    .clk_25M(clk_25M), .reset(reset), .ce(ce), .step(h_wrap), .restart(restart),
    .count(v_count), .count_nxt(v_nxt), .wrap(v_wrap),
    .sync_nxt(v_sync_nxt), .active_nxt(v_act_nxt)
  );

  always_ff @(posedge clk_25M) begin
    if (reset) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      active      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      hsync       <= h_sync_nxt;
      vsync       <= v_sync_nxt;
      active      <= act_nxt;
      line_start  <= (h_nxt == '0);
      frame_start <= (h_nxt == '0) && (v_nxt == '0);
    end
  end

`ifdef VGA_TIMING_WINDOW_EN
  localparam int CW1 = CW + 1;
  localparam logic [CW:0] WIN_W_C = CW1'(WIN_W);
  localparam logic [CW:0] WIN_H_C = CW1'(WIN_H);

  logic          frame_wrap;
  logic [CW-1:0] x0_q, y0_q, x0_nxt, y0_nxt;
  logic [CW:0]   x_end, y_end;
  logic          in_win;

  // Origin is taken only at frame boundaries (including the post-reset frame start);
  // the extra bound bit keeps a window near the right/bottom edge from wrapping to 0.
  assign frame_wrap = restart | v_wrap;

  always_comb begin
    x0_nxt = frame_wrap ? win_x0 : x0_q;
    y0_nxt = frame_wrap ? win_y0 : y0_q;
    x_end  = {1'b0, x0_nxt} + WIN_W_C;
    y_end  = {1'b0, y0_nxt} + WIN_H_C;
    in_win = act_nxt
             && (h_nxt >= x0_nxt) && ({1'b0, h_nxt} < x_end)
             && (v_nxt >= y0_nxt) && ({1'b0, v_nxt} < y_end);
  end

  always_ff @(posedge clk_25M) begin
    if (reset) begin
      x0_q   <= '0;
      y0_q   <= '0;
      win_en <= 1'b0;
      win_x  <= '0;
      win_y  <= '0;
    end else if (ce) begin
      x0_q   <= x0_nxt;
      y0_q   <= y0_nxt;
      win_en <= in_win;
      win_x  <= in_win ? (h_nxt - x0_nxt) : '0;
      win_y  <= in_win ? (v_nxt - y0_nxt) : '0;
    end
  end
`else
  logic unused_win;
  assign unused_win = ^{win_x0, win_y0, v_wrap, CW'(WIN_W), CW'(WIN_H)};
  assign win_en = 1'b0;
  assign win_x  = '0;
  assign win_y  = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default 640x480 instance for line timing, hold and mid-frame reset,
// and a shrunken positive-sync instance for whole-frame and picture-window behaviour.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

`ifdef VGA_TIMING_WINDOW_EN
  localparam bit WIN_ON = 1'b1;
`else
  localparam bit WIN_ON = 1'b0;
`endif

  typedef struct packed {
    count_t h;
    count_t v;
    logic   hs;
    logic   vs;
    logic   act;
    logic   ls;
    logic   fs;
    logic   we;
    count_t wx;
    count_t wy;
  } obs_t;

  logic clk_25M = 1'b0;
  always #20 clk_25M = ~clk_25M;

  logic   rst_d, ce_d, rst_s, ce_s;
  count_t x0_d, y0_d, x0_s, y0_s;
  count_t h_d, v_d, wx_d, wy_d, h_s, v_s, wx_s, wy_s;
  logic   hs_d, vs_d, act_d, ls_d, fs_d, we_d;
  logic   hs_s, vs_s, act_s, ls_s, fs_s, we_s;

  vga_timing_gen u_dut_def (
    .clk_25M(clk_25M), .reset(rst_d), .ce(ce_d), .win_x0(x0_d), .win_y0(y0_d),
    .h_count(h_d), .v_count(v_d), .hsync(hs_d), .vsync(vs_d), .active(act_d),
    .line_start(ls_d), .frame_start(fs_d), .win_en(we_d), .win_x(wx_d), .win_y(wy_d)
  );

  // 60x30 raster: hsync 44..49, vsync lines 22..23, 40x20 active, 10x8 window, active-high sync.
  vga_timing_gen #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(10),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(6),
    .SYNC_POL(1'b1), .WIN_W(10), .WIN_H(8), .CW(10)
  ) u_dut_sml (
    .clk_25M(clk_25M), .reset(rst_s), .ce(ce_s), .win_x0(x0_s), .win_y0(y0_s),
    .h_count(h_s), .v_count(v_s), .hsync(hs_s), .vsync(vs_s), .active(act_s),
    .line_start(ls_s), .frame_start(fs_s), .win_en(we_s), .win_x(wx_s), .win_y(wy_s)
  );

  int n_chk, n_fail;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic obs_t model(input int h, input int v, input int ha, input int hs0,
                                 input int hs1, input int va, input int vs0, input int vs1,
                                 input bit pol, input int x0, input int y0, input int ww,
                                 input int wh);
    obs_t e;
    bit   inw;
    e.h   = count_t'(h);
    e.v   = count_t'(v);
    e.hs  = (h >= hs0 && h <= hs1) ? pol : ~pol;
    e.vs  = (v >= vs0 && v <= vs1) ? pol : ~pol;
    e.act = (h < ha) && (v < va);
    e.ls  = (h == 0);
    e.fs  = (h == 0) && (v == 0);
    inw   = WIN_ON && e.act && h >= x0 && h < x0 + ww && v >= y0 && v < y0 + wh;
    e.we  = inw;
    e.wx  = inw ? count_t'(h - x0) : '0;
    e.wy  = inw ? count_t'(v - y0) : '0;
    return e;
  endfunction

  function automatic obs_t obs_def();
    obs_t o;
    o = {h_d, v_d, hs_d, vs_d, act_d, ls_d, fs_d, we_d, wx_d, wy_d};
    return o;
  endfunction

  function automatic obs_t obs_sml();
    obs_t o;
    o = {h_s, v_s, hs_s, vs_s, act_s, ls_s, fs_s, we_s, wx_s, wy_s};
    return o;
  endfunction

  initial begin
    obs_t o, e, prev, rd, rs;
    int   k, err, hold_err, hs_low, hs_first, hs_last, ls_prev, ls_period;
    int   fs_prev, fs_period, leak, lx0, ly0;
    int   wpix[2], apix[2], fsn[2], vln[2];
    logic last_ce;

    n_chk = 0;
    n_fail = 0;
    rst_d = 1'b1; ce_d = 1'b1; x0_d = '0; y0_d = '0;
    rst_s = 1'b1; ce_s = 1'b1; x0_s = 10'd12; y0_s = 10'd5;
    rd = '0; rd.hs = 1'b1; rd.vs = 1'b1;
    rs = '0;

    repeat (3) @(posedge clk_25M);
    @(negedge clk_25M);
    chk("def_reset_state", obs_def(), rd);
    chk("sml_reset_state", obs_sml(), rs);

    // Default instance: two full-speed lines, a 50% ce stretch, then run to h=123,v=45.
    rst_d = 1'b0;
    k = 0; err = 0; hold_err = 0; hs_low = 0; hs_first = -1; hs_last = -1;
    ls_prev = -1; ls_period = 0; last_ce = 1'b1; prev = '0;
    for (int c = 0; k < 45 * 800 + 123; c++) begin
      @(negedge clk_25M);
      o = obs_def();
      e = model(k % 800, (k / 800) % 525, 640, 656, 751, 480, 490, 491, 1'b0, 0, 0, 200, 200);
      if (c == 0) begin
        chk("def_first_state", o, e);
        chk("def_first_fs", fs_d, 1'b1);
        chk("def_first_ls", ls_d, 1'b1);
      end
      if (o !== e) err++;
      if (!last_ce && o !== prev) hold_err++;
      if (c < 800 && !hs_d) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(h_d);
        hs_last = int'(h_d);
      end
      if (c < 1700 && ls_d) begin
        if (ls_prev >= 0) ls_period = c - ls_prev;
        ls_prev = c;
      end
      prev = o;
      ce_d = (c < 1700 || c >= 3700) ? 1'b1 : ((c % 2) == 1);
      last_ce = ce_d;
      if (ce_d) k++;
    end
    chk("def_cycle_err", err, 0);
    chk("def_hold_err", hold_err, 0);
    chk("hsync_low_cnt", hs_low, 96);
    chk("hsync_first_low", hs_first, 656);
    chk("hsync_last_low", hs_last, 751);
    chk("line_period", ls_period, 800);

    @(negedge clk_25M);
    chk("pre_reset_hv", {h_d, v_d}, {count_t'(123), count_t'(45)});
    rst_d = 1'b1; ce_d = 1'b0;
    @(negedge clk_25M);
    chk("midrst_ce0", obs_def(), rd);
    ce_d = 1'b1;
    @(negedge clk_25M);
    chk("midrst_ce1", obs_def(), rd);
    rst_d = 1'b0; ce_d = 1'b0;
    @(negedge clk_25M);
    chk("post_rst_hold", obs_def(), rd);
    ce_d = 1'b1;
    @(negedge clk_25M);
    chk("restart_state", obs_def(),
        model(0, 0, 640, 656, 751, 480, 490, 491, 1'b0, 0, 0, 200, 200));
    chk("restart_fs", fs_d, 1'b1);
    @(negedge clk_25M);
    chk("restart_next_h", h_d, count_t'(1));
    chk("restart_next_fs", fs_d, 1'b0);

    // Small instance: two frames, origin moved mid-frame from x=12 to x=35 (clipped at 40).
    rst_s = 1'b0;
    err = 0; leak = 0; lx0 = 0; ly0 = 0; fs_prev = -1; fs_period = 0;
    for (int f = 0; f < 2; f++) begin
      wpix[f] = 0; apix[f] = 0; fsn[f] = 0; vln[f] = 0;
    end
    for (k = 0; k < 2 * 1800 + 5; k++) begin
      @(negedge clk_25M);
      if (k % 1800 == 0) begin
        lx0 = int'(x0_s);
        ly0 = int'(y0_s);
      end
      o = obs_sml();
      e = model(k % 60, (k / 60) % 30, 40, 44, 49, 20, 22, 23, 1'b1, lx0, ly0, 10, 8);
      if (k == 0) chk("sml_first_fs", fs_s, 1'b1);
      if (o !== e) err++;
      if (we_s && !act_s) leak++;
      if (fs_s) begin
        if (fs_prev >= 0) fs_period = k - fs_prev;
        fs_prev = k;
      end
      if (k < 3600) begin
        if (we_s) wpix[k / 1800]++;
        if (act_s) apix[k / 1800]++;
        if (fs_s) fsn[k / 1800]++;
        if (vs_s && h_s == '0) vln[k / 1800]++;
      end
      if (k == 5 * 60 + 12) begin
        chk("win_left_en", we_s, WIN_ON);
        chk("win_left_x", wx_s, 0);
      end
      if (k == 5 * 60 + 21) begin
        chk("win_right_en", we_s, WIN_ON);
        chk("win_right_x", wx_s, WIN_ON ? 9 : 0);
      end
      if (k == 12 * 60 + 15) chk("win_bottom_y", wy_s, WIN_ON ? 7 : 0);
      if (k == 1800 + 5 * 60 + 12) chk("old_origin_gone", we_s, 1'b0);
      if (k == 1800 + 5 * 60 + 39) begin
        chk("clip_edge_en", we_s, WIN_ON);
        chk("clip_edge_x", wx_s, WIN_ON ? 4 : 0);
      end
      if (k == 1800 + 5 * 60 + 40) chk("clip_no_wrap", we_s, 1'b0);
      if (k == 900) x0_s = 10'd35;
    end
    chk("sml_cycle_err", err, 0);
    chk("sml_win_leak", leak, 0);
    chk("frame_period", fs_period, 1800);
    chk("frame0_win_pix", wpix[0], WIN_ON ? 80 : 0);
    chk("frame1_win_pix", wpix[1], WIN_ON ? 40 : 0);
    chk("frame0_act_pix", apix[0], 800);
    chk("frame1_act_pix", apix[1], 800);
    chk("frame0_fs_cnt", fsn[0], 1);
    chk("frame1_fs_cnt", fsn[1], 1);
    chk("frame0_vs_lines", vln[0], 2);
    chk("frame1_vs_lines", vln[1], 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have one clock, clk_25M, and one reset, reset, which is synchronous and active-high.
REQ-002 Parameters SHALL be:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, sync asserted level (0 = active-low)
- WIN_W, 200, picture window width
- WIN_H, 200, picture window height
- CW, 10, counter width
REQ-003 Ports SHALL be:
- clk_25M  in  1  pixel clock
- reset  in  1  synchronous active-high reset
- ce  in  1  pixel-advance enable
- win_x0  in  CW  window left edge, active-area coordinates
- win_y0  in  CW  window top edge
- h_count  out  CW  horizontal position
- v_count  out  CW  vertical position
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- active  out  1  visible area
- line_start  out  1  one-cycle pulse at h_count==0
- frame_start  out  1  one-cycle pulse at h_count==0 and v_count==0
- win_en  out  1  pixel inside picture window
- win_x  out  CW  pixel column within the window
- win_y  out  CW  pixel row within the window

Function
REQ-004 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL SHALL be defined likewise (defaults 800 and 525).
REQ-005 When ce=1, h_count SHALL step 0..H_TOTAL-1, then wrap to 0; when ce=0, all state and outputs SHALL hold.
REQ-006 v_count SHALL increment only on a ce cycle in which h_count wraps, and SHALL wrap from V_TOTAL-1 to 0 at that same point.
REQ-007 Each axis SHALL be ordered active, front porch, sync, back porch; hsync is asserted for h_count in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751 by default), and vsync likewise for lines 490..491.
REQ-008 The asserted level of hsync and vsync SHALL be SYNC_POL; the deasserted level SHALL be its inverse.
REQ-009 active SHALL be 1 iff h_count<H_ACTIVE and v_count<V_ACTIVE.
REQ-010 All outputs SHALL be registered and SHALL describe the h_count/v_count values presented in the same cycle (zero relative skew, decoded from next-state counters).
REQ-011 win_x0/win_y0 SHALL be latched only on the ce cycle in which both counters wrap, so the origin is constant for a whole frame.
REQ-012 win_en SHALL be 1 iff active=1, h_count is in [x0, x0+WIN_W-1] and v_count is in [y0, y0+WIN_H-1], using the latched origin.
REQ-013 Window bounds SHALL be computed at CW+1 bits; a window extending past the active area SHALL be clipped, not wrapped.
REQ-014 win_x SHALL equal h_count-x0 and win_y SHALL equal v_count-y0 when win_en=1; both SHALL be 0 otherwise.

Reset
REQ-015 While reset=1 (regardless of ce):
- h_count, v_count, win_x and win_y SHALL be 0.
- active and win_en SHALL be 0; line_start and frame_start SHALL be 0.
- hsync and vsync SHALL be at the deasserted level.
- The latched origin SHALL be 0.
REQ-016 On the first ce cycle after reset deasserts, the counters SHALL be at 0,0 with frame_start=1 and line_start=1; reset asserted mid-frame SHALL restart the frame.

Configuration
REQ-017 With VGA_TIMING_WINDOW_EN defined, the window logic (REQ-011..014) SHALL be present.
REQ-018 Without VGA_TIMING_WINDOW_EN, win_en, win_x and win_y SHALL be tied to 0, win_x0/win_y0 SHALL be ignored, and no window registers SHALL be synthesised.

Structure
REQ-019 Package vga_timing_pkg SHALL hold the default 640x480@60 timing constants, the derived-total function, and the counter typedef.
REQ-020 One sub-module, vga_axis_counter, SHALL be instantiated once per axis; each instance provides the counter, wrap, sync and active decodes.

Verification
REQ-021 Default parameters, ce=1 for 2 frames -> hsync low for h_count 656..751; line period 800 cycles; frame period 420000 cycles.
REQ-022 Frame timing -> vsync low on lines 490..491; active count per frame = 307200; one frame_start pulse per frame.
REQ-023 win_x0=200, win_y0=100 -> win_en for h 200..399, v 100..299; win_x=0 at h=200, win_x=199 at h=399; 40000 window pixels per frame.
REQ-024 Change win_x0 from 200 to 300 mid-frame -> current frame is unchanged; the new origin applies from the next frame_start.
REQ-025 win_x0=600 -> window clipped to h 600..639, giving 40 pixels per line with no wrap into the blanking area.
REQ-026 Toggle ce at 50% -> all outputs hold on ce=0; assert reset at h=123, v=45 -> the next ce cycle shows 0,0 with frame_start=1.
